// File: rtl/fp_mult_pipe_if.sv
// fp_mult_pipe_if: operand/result handshake bundle for the pipelined multiplier
interface fp_mult_pipe_if #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int TAG_W = 4
);
   localparam int W = 1 + EXP_W + MAN_W;
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     in_a;
   logic [W-1:0]     in_b;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     out_result;
   logic [TAG_W-1:0] out_tag;
   logic [3:0]       out_flags;
   modport master (
      output in_valid, in_a, in_b, in_tag, out_ready,
      input  in_ready, out_valid, out_result, out_tag, out_flags
   );
   modport slave (
      input  in_valid, in_a, in_b, in_tag, out_ready,
      output in_ready, out_valid, out_result, out_tag, out_flags
   );
endinterface

// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: three-stage IEEE-style multiplier (unpack, multiply, round/pack) with stall-all flow control
module fp_mult_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int TAG_W = 4
) (
   input logic           clk,
   input logic           rst_n,
   fp_mult_pipe_if.slave bus
);
   localparam int W    = 1 + EXP_W + MAN_W;
   localparam int BIAS = 2**(EXP_W-1) - 1;
   localparam int EMAX = 2**EXP_W - 1;
   localparam int PW   = 2 * (MAN_W + 1);
   localparam int XW   = EXP_W + 2;
   logic             adv;
   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W-1:0] fa, fb;
   logic             nan_d, inf_d, zero_d;
   logic             v1_q, sign1_q, nan1_q, inf1_q, zero1_q;
   logic [EXP_W-1:0] ea1_q, eb1_q;
   logic [MAN_W:0]   ma1_q, mb1_q;
   logic [TAG_W-1:0] tag1_q;
   logic             v2_q, sign2_q, nan2_q, inf2_q, zero2_q;
   logic [XW-1:0]    exp2_q;
   logic [PW-1:0]    prod2_q;
   logic [TAG_W-1:0] tag2_q;
   logic             hi, g, r, s, ovf, unf;
   logic [MAN_W:0]   mant;
   logic [MAN_W+1:0] rnd;
   logic [MAN_W-1:0] frac;
   logic [XW-1:0]    ef;
   logic [W-1:0]     inf_w, zero_w, res_d;
   logic [3:0]       flags_d;
   logic             v3_q;
   logic [W-1:0]     res_q;
   logic [TAG_W-1:0] tag3_q;
   logic [3:0]       flags_q;
   assign adv            = !v3_q || bus.out_ready;
   assign bus.in_ready   = adv;
   assign bus.out_valid  = v3_q;
   assign bus.out_result = res_q;
   assign bus.out_tag    = tag3_q;
   assign bus.out_flags  = flags_q;
   assign ea = bus.in_a[W-2:MAN_W];
   assign eb = bus.in_b[W-2:MAN_W];
   assign fa = bus.in_a[MAN_W-1:0];
   assign fb = bus.in_b[MAN_W-1:0];
   // Classify operands; exp==0 covers both true zeros and flushed subnormals
   always_comb begin
      nan_d  = (ea == EXP_W'(EMAX) && fa != '0) || (eb == EXP_W'(EMAX) && fb != '0) ||
               (ea == '0 && eb == EXP_W'(EMAX)) || (eb == '0 && ea == EXP_W'(EMAX));
      inf_d  = ea == EXP_W'(EMAX) || eb == EXP_W'(EMAX);
      zero_d = ea == '0 || eb == '0;
   end
   // S1: capture classification and unpacked operands
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q    <= 1'b0;
         sign1_q <= 1'b0;
         nan1_q  <= 1'b0;
         inf1_q  <= 1'b0;
         zero1_q <= 1'b0;
         ea1_q   <= '0;
         eb1_q   <= '0;
         ma1_q   <= '0;
         mb1_q   <= '0;
         tag1_q  <= '0;
      end else if (adv) begin
         v1_q    <= bus.in_valid;
         sign1_q <= bus.in_a[W-1] ^ bus.in_b[W-1];
         nan1_q  <= nan_d;
         inf1_q  <= inf_d;
         zero1_q <= zero_d;
         ea1_q   <= ea;
         eb1_q   <= eb;
         ma1_q   <= {1'b1, fa};
         mb1_q   <= {1'b1, fb};
         tag1_q  <= bus.in_tag;
      end
   end
   // S2: full mantissa product and biased exponent sum, wide enough never to wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2_q    <= 1'b0;
         sign2_q <= 1'b0;
         nan2_q  <= 1'b0;
         inf2_q  <= 1'b0;
         zero2_q <= 1'b0;
         exp2_q  <= '0;
         prod2_q <= '0;
         tag2_q  <= '0;
      end else if (adv) begin
         v2_q    <= v1_q;
         sign2_q <= sign1_q;
         nan2_q  <= nan1_q;
         inf2_q  <= inf1_q;
         zero2_q <= zero1_q;
         exp2_q  <= XW'(ea1_q) + XW'(eb1_q) - XW'(BIAS);
         prod2_q <= PW'(ma1_q) * PW'(mb1_q);
         tag2_q  <= tag1_q;
      end
   end
   // S3 logic: normalise, round to nearest even, detect range errors, pack
   always_comb begin
      hi      = prod2_q[PW-1];
      mant    = hi ? prod2_q[PW-1:MAN_W+1] : prod2_q[PW-2:MAN_W];
      g       = hi ? prod2_q[MAN_W]        : prod2_q[MAN_W-1];
      r       = hi ? prod2_q[MAN_W-1]      : prod2_q[MAN_W-2];
      s       = hi ? |prod2_q[MAN_W-2:0]   : |prod2_q[MAN_W-3:0];
      rnd     = {1'b0, mant} + (MAN_W+2)'(g && (r || s || mant[0]));
      frac    = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
      ef      = exp2_q + XW'(hi) + XW'(rnd[MAN_W+1]);
      ovf     = !ef[XW-1] && ef[XW-2:0] >= (XW-1)'(EMAX);
      unf     = ef[XW-1] || ef == '0;
      inf_w   = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      zero_w  = {sign2_q, {(W-1){1'b0}}};
      res_d   = nan2_q  ? {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}} :
                inf2_q  ? inf_w :
                zero2_q ? zero_w :
                ovf     ? inf_w :
                unf     ? zero_w : {sign2_q, ef[EXP_W-1:0], frac};
      flags_d = nan2_q             ? 4'b1000 :
                inf2_q || zero2_q  ? 4'b0000 :
                ovf                ? 4'b0101 :
                unf                ? 4'b0011 : {3'b000, g | r | s};
   end
   // S3: output register, held while the consumer stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v3_q    <= 1'b0;
         res_q   <= '0;
         tag3_q  <= '0;
         flags_q <= '0;
      end else if (adv) begin
         v3_q    <= v2_q;
         res_q   <= res_d;
         tag3_q  <= tag2_q;
         flags_q <= flags_d;
      end
   end
endmodule
